// File: rtl/alu_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mult_seq
//  Description : Shift-and-add multiplier that borrows the shared pipeline ALU
//                (ADD only) to build the low NB_DATA bits of a*b, one partial
//                product per granted cycle. Optional early termination when
//                the remaining multiplier is zero: MULT_SEQ_EARLY_EXIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mult_seq #(
    parameter int NB_DATA      = 32,
    parameter int NB_OPERATION = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [NB_DATA-1:0]      i_data_a,
    input  logic [NB_DATA-1:0]      i_data_b,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [NB_DATA-1:0]      o_result,
    output logic                    o_alu_req,
    input  logic                    i_alu_gnt,
    output logic [NB_OPERATION-1:0] o_alu_op,
    output logic [NB_DATA-1:0]      o_alu_a,
    output logic [NB_DATA-1:0]      o_alu_b,
    input  logic [NB_DATA-1:0]      i_alu_result
);

    localparam int                      c_NB_CNT   = $clog2(NB_DATA) + 1;
    localparam logic [c_NB_CNT-1:0]     c_LAST_CNT = c_NB_CNT'(NB_DATA - 1);
    localparam logic [NB_OPERATION-1:0] c_OP_ADD   = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [NB_DATA-1:0]    r_acc;
    logic [NB_DATA-1:0]    r_m;
    logic [NB_DATA-1:0]    r_q;
    logic [NB_DATA-1:0]    r_result;
    logic [c_NB_CNT-1:0]   r_cnt;

    logic                  w_start_ok;
    logic                  w_early_exit;
    logic                  w_step;
    logic                  w_last;
    logic [NB_DATA-1:0]    w_acc_next;

    // Once the multiplier is exhausted the remaining iterations only add zero.
`ifdef MULT_SEQ_EARLY_EXIT_EN
    assign w_early_exit = (r_state == ST_RUN) && (r_q == '0);
`else
    assign w_early_exit = 1'b0;
`endif

    assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step     = (r_state == ST_RUN) && !w_early_exit && i_alu_gnt;
    assign w_last     = w_step && (r_cnt == c_LAST_CNT);
    assign w_acc_next = r_q[0] ? i_alu_result : r_acc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_alu_req    = 1'b0;
        o_alu_op     = c_OP_ADD;
        o_alu_a      = '0;
        o_alu_b      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                o_busy    = 1'b1;
                o_alu_req = !w_early_exit;
                o_alu_a   = r_acc;
                o_alu_b   = r_m;
                if (w_early_exit || w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = w_start_ok ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: start load, one shift-and-add step per granted RUN cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_m   <= i_data_a;
            r_q   <= i_data_b;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_next;
            r_m   <= r_m << 1;
            r_q   <= r_q >> 1;
            r_cnt <= r_cnt + c_NB_CNT'(1);
            if (w_last) r_result <= w_acc_next;
        end else if (w_early_exit) begin
            r_result <= r_acc;
        end
    end

    assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mult_seq
//  Description : Randomized self-checking bench for alu_mult_seq with a
//                behavioural product/latency model and an ideal shared ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mult_seq;

    localparam int NB_DATA = 32;
    localparam int NB_OP   = 4;
    localparam int TIMEOUT = 300;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_start = 1'b0;
    logic [NB_DATA-1:0] i_data_a = '0;
    logic [NB_DATA-1:0] i_data_b = '0;
    logic               o_busy;
    logic               o_done;
    logic [NB_DATA-1:0] o_result;
    logic               o_alu_req;
    logic               i_alu_gnt = 1'b1;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_DATA-1:0] i_alu_result;

    int n_vec = 0;
    int n_err = 0;
    logic [NB_DATA-1:0] model_res = '0;

    always #5 i_clock = ~i_clock;

    // Ideal shared ALU executing ADD with zero latency.
    assign i_alu_result = o_alu_a + o_alu_b;

    alu_mult_seq #(.NB_DATA(NB_DATA), .NB_OPERATION(NB_OP)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_data_a(i_data_a), .i_data_b(i_data_b),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
        .o_alu_req(o_alu_req), .i_alu_gnt(i_alu_gnt), .o_alu_op(o_alu_op),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .i_alu_result(i_alu_result)
    );

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Granted iterations needed before the result is complete.
    function automatic int req_iters(input logic [NB_DATA-1:0] b);
        int k = 0;
        for (int i = 0; i < NB_DATA; i++) if (b[i]) k = i + 1;
        if (!EARLY_EXIT) k = NB_DATA;
        return k;
    endfunction

    // Drives one multiplication from the current cycle (which may be a done
    // cycle) and measures completion; mode 0 full grant, 1 stall cycles 2-4,
    // 2 random grant.
    task automatic do_mult(input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b,
                           input int mode, input bit spurious,
                           output int done_cyc, output logic [NB_DATA-1:0] res,
                           output int exp_done, output int busy_cnt,
                           output int req_low, output int exp_req_low,
                           output int hold_bad);
        int k;
        int g_cnt;
        logic g;
        k           = req_iters(b);
        g_cnt       = 0;
        done_cyc    = -1;
        res         = '0;
        busy_cnt    = 0;
        req_low     = 0;
        hold_bad    = 0;
        exp_done    = (k == 0) ? 2 : -2;
        exp_req_low = (k < NB_DATA) ? 1 : 0;
        i_data_a = a;
        i_data_b = b;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            case (mode)
                0:       g = 1'b1;
                1:       g = !(cyc >= 2 && cyc <= 4);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            i_alu_gnt = g;
            if (spurious && cyc == 5) begin
                i_start  = 1'b1;
                i_data_a = $urandom;
                i_data_b = $urandom;
            end else begin
                i_start = 1'b0;
            end
            if (g && g_cnt < k) begin
                g_cnt++;
                if (g_cnt == k) exp_done = (k == NB_DATA) ? cyc + 1 : cyc + 2;
            end
            if (o_done) begin
                done_cyc = cyc;
                res      = o_result;
                break;
            end
            if (o_busy) busy_cnt++;
            if (o_busy && !o_alu_req) req_low++;
            if (o_busy && o_result !== model_res) hold_bad++;
            step();
        end
        i_start   = 1'b0;
        i_alu_gnt = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        step();
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_done); end
        n_vec++; if (o_alu_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", o_alu_req); end
        n_vec++; if (o_result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 0", o_result); end
        n_vec++; if (o_alu_a !== '0 || o_alu_b !== '0) begin n_err++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", o_alu_a, o_alu_b); end
        n_vec++; if (o_alu_op !== 4'b0000) begin n_err++; $display("FAIL reset_op: got %b expected 0000", o_alu_op); end
        i_reset   = 1'b0;
        model_res = '0;
        step();
    endtask

    task automatic test_directed();
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        do_mult(32'd7, 32'd6, 0, 1'b0, dc, r, ed, bc, rl, erl, hb);
        n_vec++; if (r !== 32'd42) begin n_err++; $display("FAIL dir_result: got %0d expected 42", r); end
        n_vec++; if (dc !== ed) begin n_err++; $display("FAIL dir_done_cycle: got %0d expected %0d", dc, ed); end
`ifndef MULT_SEQ_EARLY_EXIT_EN
        n_vec++; if (dc !== 33) begin n_err++; $display("FAIL dir_done_33: got %0d expected 33", dc); end
        n_vec++; if (bc !== 32) begin n_err++; $display("FAIL dir_busy_32: got %0d expected 32", bc); end
`endif
        n_vec++; if (rl !== erl) begin n_err++; $display("FAIL dir_req_low: got %0d expected %0d", rl, erl); end
        n_vec++; if (hb !== 0) begin n_err++; $display("FAIL dir_hold: got %0d bad cycles expected 0", hb); end
        model_res = 32'd42;
        step();
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL dir_done_pulse: got %b expected 0", o_done); end
        n_vec++; if (o_result !== 32'd42) begin n_err++; $display("FAIL dir_result_held: got %0d expected 42", o_result); end
        n_vec++; if (o_alu_a !== '0 || o_alu_b !== '0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL dir_idle_outputs: got a=%h b=%h busy=%b expected 0/0/0", o_alu_a, o_alu_b, o_busy);
        end
    endtask

    task automatic test_corners();
        logic [NB_DATA-1:0] a_tab [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd100, 32'd100};
        logic [NB_DATA-1:0] b_tab [4] = '{32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0};
        logic [NB_DATA-1:0] p_tab [4] = '{32'h0000_0001, 32'h0000_0000, 32'd100, 32'd0};
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        for (int i = 0; i < 4; i++) begin
            do_mult(a_tab[i], b_tab[i], 0, 1'b0, dc, r, ed, bc, rl, erl, hb);
            n_vec++; if (r !== p_tab[i]) begin n_err++; $display("FAIL corner%0d_result: got %h expected %h", i, r, p_tab[i]); end
            n_vec++; if (dc !== ed) begin n_err++; $display("FAIL corner%0d_done_cycle: got %0d expected %0d", i, dc, ed); end
            n_vec++; if (bc !== ed - 1) begin n_err++; $display("FAIL corner%0d_busy: got %0d expected %0d", i, bc, ed - 1); end
`ifdef MULT_SEQ_EARLY_EXIT_EN
            if (i == 2) begin
                n_vec++; if (dc !== 3) begin n_err++; $display("FAIL early_b1_cycle: got %0d expected 3", dc); end
            end
            if (i == 3) begin
                n_vec++; if (dc !== 2) begin n_err++; $display("FAIL early_b0_cycle: got %0d expected 2", dc); end
            end
`endif
            model_res = p_tab[i];
            step();
        end
    endtask

    task automatic test_stall();
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        do_mult(32'd3, 32'd5, 1, 1'b0, dc, r, ed, bc, rl, erl, hb);
        n_vec++; if (r !== 32'd15) begin n_err++; $display("FAIL stall_result: got %0d expected 15", r); end
        n_vec++; if (dc !== ed) begin n_err++; $display("FAIL stall_done_cycle: got %0d expected %0d", dc, ed); end
`ifndef MULT_SEQ_EARLY_EXIT_EN
        n_vec++; if (dc !== 36) begin n_err++; $display("FAIL stall_done_36: got %0d expected 36", dc); end
`endif
        n_vec++; if (rl !== erl) begin n_err++; $display("FAIL stall_req_low: got %0d expected %0d", rl, erl); end
        model_res = 32'd15;
        step();
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        i_data_a  = 32'd7;
        i_data_b  = 32'hF000_0001;
        i_start   = 1'b1;
        i_alu_gnt = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b expected 1", o_busy); end
        i_reset = 1'b1;
        step();
        i_reset   = 1'b0;
        model_res = '0;
        n_vec++; if ({o_busy, o_done, o_alu_req} !== 3'b000) begin
            n_err++; $display("FAIL midrst_flags: got busy/done/req=%b expected 000", {o_busy, o_done, o_alu_req});
        end
        n_vec++; if (o_result !== '0 || o_alu_a !== '0 || o_alu_b !== '0) begin
            n_err++; $display("FAIL midrst_data: got res=%h a=%h b=%h expected all 0", o_result, o_alu_a, o_alu_b);
        end
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done || o_busy) seen_done++;
            step();
        end
        n_vec++; if (seen_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done); end
        do_mult(32'd2, 32'd9, 0, 1'b0, dc, r, ed, bc, rl, erl, hb);
        n_vec++; if (r !== 32'd18) begin n_err++; $display("FAIL midrst_restart: got %0d expected 18", r); end
        n_vec++; if (dc !== ed) begin n_err++; $display("FAIL midrst_restart_cycle: got %0d expected %0d", dc, ed); end
        model_res = 32'd18;
        step();
    endtask

    task automatic test_start_ignored();
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        logic [NB_DATA-1:0] a = 32'h0000_1234;
        logic [NB_DATA-1:0] b = 32'h8000_0003;
        logic [NB_DATA-1:0] p;
        p = a * b;
        do_mult(a, b, 0, 1'b1, dc, r, ed, bc, rl, erl, hb);
        n_vec++; if (r !== p) begin n_err++; $display("FAIL ignored_start_result: got %h expected %h", r, p); end
        n_vec++; if (dc !== ed) begin n_err++; $display("FAIL ignored_start_cycle: got %0d expected %0d", dc, ed); end
        model_res = p;
    endtask

    task automatic test_back_to_back();
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r;
        logic [NB_DATA-1:0] a = 32'hDEAD_BEEF;
        logic [NB_DATA-1:0] b = 32'h8765_4321;
        logic [NB_DATA-1:0] p;
        p = a * b;
        // Called while the previous operation's done pulse is still high.
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL b2b_in_done_cycle: got %b expected 1", o_done); end
        do_mult(a, b, 0, 1'b0, dc, r, ed, bc, rl, erl, hb);
        n_vec++; if (r !== p) begin n_err++; $display("FAIL b2b_result: got %h expected %h", r, p); end
        n_vec++; if (dc !== ed) begin n_err++; $display("FAIL b2b_done_cycle: got %0d expected %0d", dc, ed); end
`ifndef MULT_SEQ_EARLY_EXIT_EN
        n_vec++; if (dc !== 33) begin n_err++; $display("FAIL b2b_done_33: got %0d expected 33", dc); end
`endif
        n_vec++; if (hb !== 0) begin n_err++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", hb); end
        model_res = p;
        step();
    endtask

    task automatic test_random();
        int dc, ed, bc, rl, erl, hb;
        logic [NB_DATA-1:0] r, a, b, p;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            p = a * b;
            do_mult(a, b, 2, 1'b0, dc, r, ed, bc, rl, erl, hb);
            n_vec++; if (r !== p) begin n_err++; $display("FAIL rand%0d_result: got %h expected %h (a=%h b=%h)", i, r, p, a, b); end
            n_vec++; if (dc !== ed) begin n_err++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", i, dc, ed); end
            n_vec++; if (hb !== 0) begin n_err++; $display("FAIL rand%0d_hold: got %0d bad cycles expected 0", i, hb); end
            model_res = p;
            if ($urandom_range(0, 1) == 0) step();
        end
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_corners();
        test_stall();
        test_reset_mid_run();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
